// File: rtl/mem_port_initiator.sv
// mem_port_initiator: load/store initiator for a single-port synchronous data memory
//
// Accepts load/store requests over a valid/ready handshake and drives the
// memory pins combinationally from the request. Read data returns one cycle
// after the address and is captured into a 2-entry response FIFO, so load
// results reach the consumer in order even while it stalls.
//
// Optional feature macro: MEM_PORT_INITIATOR_RANGE_CHECK_EN
//   defined   - addresses above MEM_LEN are out of range: stores are dropped
//               (wr_err pulses), loads return data 0 with resp_err set
//   undefined - every address is in range, resp_err and wr_err stay 0
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (acc = req_valid & req_ready)
//   req_we                  1 = store, 0 = load
//   req_addr, req_wdata     word address and store data
//   resp_valid/resp_ready   response handshake, FIFO head
//   resp_data, resp_err     load result and out-of-range tag
//   wr_err                  one-cycle pulse for a dropped store
//   busy                    a load is in flight or a result is waiting
//   mem_a, mem_w, mem_d     memory address, write enable, write data
//   mem_q                   memory read data, one cycle after mem_a
module mem_port_initiator #(
    parameter int MEM_ADDR = 16,
    parameter int LEN_REG  = 32,
    parameter int MEM_LEN  = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [MEM_ADDR-1:0] req_addr,
    input  logic [LEN_REG-1:0]  req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [LEN_REG-1:0]  resp_data,
    output logic                resp_err,
    output logic                wr_err,
    output logic                busy,
    output logic [MEM_ADDR-1:0] mem_a,
    output logic                mem_w,
    output logic [LEN_REG-1:0]  mem_d,
    input  logic [LEN_REG-1:0]  mem_q
);
`ifdef MEM_PORT_INITIATOR_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic                in_range;
    logic                acc;
    logic                pop;
    logic                push;
    logic [2:0]          occ;
    logic [LEN_REG-1:0]  push_data;
    logic                rd_pend_q, rd_pend_d;
    logic                err_q, err_d;
    logic [1:0]          count_q, count_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [LEN_REG-1:0]  data_q [2];
    logic [LEN_REG-1:0]  data_d [2];
    logic [1:0]          ferr_q, ferr_d;

    assign mem_a      = req_addr;
    assign mem_d      = req_wdata;
    assign resp_valid = (count_q != 2'd0);
    assign resp_data  = data_q[rd_ptr_q];
    assign resp_err   = RANGE_CHECK & ferr_q[rd_ptr_q];
    assign busy       = rd_pend_q | resp_valid;

    always_comb begin
        in_range  = RANGE_CHECK ? (req_addr <= MEM_ADDR'(MEM_LEN)) : 1'b1;
        pop       = resp_valid & resp_ready;
        // Slots already claimed (FIFO entries plus the read in flight), less
        // the one freed this cycle; one more load is allowed only if it fits.
        occ       = {1'b0, count_q} + {2'b0, rd_pend_q} - {2'b0, pop};
        req_ready = rst_n & (occ <= 3'd1);
        acc       = req_valid & req_ready;
        mem_w     = acc & req_we & in_range & rst_n;
        wr_err    = RANGE_CHECK & acc & req_we & ~in_range;
        rd_pend_d = acc & ~req_we;
        err_d     = ~in_range;
        // The read issued last cycle lands now; out-of-range reads carry 0.
        push      = rd_pend_q;
        push_data = err_q ? '0 : mem_q;
        data_d[0] = (push && !wr_ptr_q) ? push_data : data_q[0];
        data_d[1] = (push &&  wr_ptr_q) ? push_data : data_q[1];
        ferr_d[0] = (push && !wr_ptr_q) ? err_q : ferr_q[0];
        ferr_d[1] = (push &&  wr_ptr_q) ? err_q : ferr_q[1];
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            ferr_q    <= 2'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
            ferr_q    <= ferr_d;
        end
    end
endmodule

// File: tb/tb_mem_port_initiator.sv
// tb_mem_port_initiator: randomized and directed checks of mem_port_initiator
//
// A behavioural memory sits on the mem_* pins. The reference keeps its own
// copy of memory and a queue of outstanding loads, each tagged with the cycle
// its result becomes visible; every cycle all outputs are compared.
module tb_mem_port_initiator;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ML = 255;
`ifdef MEM_PORT_INITIATOR_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_ready = 1'b0;
    logic          req_ready, resp_valid, resp_err, wr_err, busy, mem_w;
    logic [DW-1:0] resp_data, mem_d, mem_q;
    logic [AW-1:0] mem_a;

    mem_port_initiator #(.MEM_ADDR(AW), .LEN_REG(DW), .MEM_LEN(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .wr_err(wr_err), .busy(busy),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dmem [0:65535];
    always @(posedge clk) begin
        if (mem_w) dmem[mem_a] <= mem_d;
        mem_q <= dmem[mem_a];
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            vis;
    } ent_t;

    ent_t          outq[$];
    logic [DW-1:0] ref_mem [0:65535];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the reference,
    // then advance the reference to what the coming edge will do.
    task automatic step(input logic rst, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic rr, output logic accepted);
        logic inr, ev, pop, er;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = rst; req_valid = v; req_we = we; req_addr = a;
        req_wdata = wd; resp_ready = rr;
        @(negedge clk);
        if (!rst) outq.delete();
        inr = RC ? (a <= AW'(ML)) : 1'b1;
        ev  = (outq.size() > 0) && (outq[0].vis <= cyc);
        pop = ev && rr;
        er  = rst && ((outq.size() - int'(pop)) <= 1);
        accepted = v && er;
        check("req_ready", {31'b0, req_ready}, {31'b0, er});
        check("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
        if (ev) begin
            check("resp_data", resp_data, outq[0].d);
            check("resp_err", {31'b0, resp_err}, {31'b0, outq[0].e});
        end
        check("mem_w", {31'b0, mem_w}, {31'b0, accepted && we && inr});
        check("wr_err", {31'b0, wr_err}, {31'b0, RC && accepted && we && !inr});
        check("busy", {31'b0, busy}, {31'b0, outq.size() > 0});
        check("mem_a", {16'b0, mem_a}, {16'b0, a});
        if (!rst) begin
            check("rst_resp_data", resp_data, '0);
            check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        end
        if (pop) void'(outq.pop_front());
        if (accepted) begin
            if (we) begin
                if (inr) ref_mem[a] = wd;
            end else begin
                outq.push_back('{inr ? ref_mem[a] : '0, !inr, cyc + 2});
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return AW'($urandom_range(0, 15));
        if (r < 9) return AW'($urandom_range(16'h00F8, 16'h0107));
        return 16'hFFFF;
    endfunction

    initial begin
        logic acc;
        int idx;
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, acc);
        // Store then immediate load of the same address.
        step(1, 1, 1, 16'h0010, 32'hDEADBEEF, 1, acc);
        step(1, 1, 0, 16'h0010, 0, 1, acc);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, acc);
        // Preload 0..3, then four back-to-back loads with the consumer ready.
        for (int i = 0; i < 4; i++) step(1, 1, 1, AW'(i), 32'h11 * (i + 1), 1, acc);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, AW'(i), 0, 1, acc);
            check("b2b_accept", {31'b0, acc}, 32'd1);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, acc);
        // Same loads against a stalled consumer, released after six cycles.
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            step(1, 1, 0, AW'(idx), 0, c >= 6, acc);
            if (acc) idx++;
        end
        check("stall_all_accepted", idx, 4);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, acc);
        // Reset right after an accepted load.
        step(1, 1, 0, 16'h0002, 0, 1, acc);
        step(0, 1, 1, 16'h0003, 32'h5555AAAA, 1, acc);
        step(0, 1, 0, 16'h0003, 0, 1, acc);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, acc);
        // Range boundary around MEM_LEN.
        step(1, 1, 1, 16'h00FF, 32'hCAFEF00D, 1, acc);
        step(1, 1, 1, 16'h0100, 32'hBAD0BAD0, 1, acc);
        step(1, 1, 0, 16'h0100, 0, 1, acc);
        step(1, 1, 0, 16'h00FF, 0, 1, acc);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, acc);
        // Fill every address the random phase can touch.
        for (int i = 0; i < 16; i++) step(1, 1, 1, AW'(i), $urandom, 1, acc);
        for (int i = 16'h00F8; i <= 16'h0107; i++) step(1, 1, 1, AW'(i), $urandom, 1, acc);
        step(1, 1, 1, 16'hFFFF, $urandom, 1, acc);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 4, rand_addr(), $urandom,
                 $urandom_range(0, 9) < 7, acc);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1, acc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_initiator.md
# mem_port_initiator

Initiator for the single-port synchronous data memory (one-cycle registered read, write-or-read per cycle). It accepts load/store requests from the execute stage over a valid/ready handshake and drives the memory's address, write-enable and write-data pins. It captures returned read data into a 2-entry response FIFO, so load results reach writeback in order even when writeback stalls. It sits between the CPU pipeline and the data memory.

## Interface
- MEM_ADDR, 16, address width; supplied by the shared `defs_insn.v` parameter header.
- LEN_REG, 32, data word width; supplied by the shared `defs_insn.v` parameter header.
- MEM_LEN, 65535, highest valid word address.
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high together with req_valid.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  MEM_ADDR  word address.
- req_wdata  input  LEN_REG  store data.
- resp_valid  output  1  load result available.
- resp_ready  input  1  consumer takes result.
- resp_data  output  LEN_REG  load result.
- resp_err  output  1  load was out of range (see Configuration).
- wr_err  output  1  one-cycle pulse: store dropped as out of range.
- busy  output  1  a load is pending or the FIFO is non-empty.
- mem_a  output  MEM_ADDR  memory address.
- mem_w  output  1  memory write enable.
- mem_d  output  LEN_REG  memory write data.
- mem_q  input  LEN_REG  memory read data; valid the cycle after the read address was presented.

## Operation
- Accept condition: acc = req_valid & req_ready.
- mem_a = req_addr and mem_d = req_wdata, both combinational.
- mem_w = acc & req_we & in_range & rst_n. mem_w is never high during reset.
- Store: written at the accepting edge. No response. Zero added latency.
- Load: on acc & !req_we, set rd_pend and latch the tag err = !in_range.
- Next cycle: push {mem_q, err} into the FIFO. When err=1, push data 0 instead of mem_q.
- Cycles without an accepted load still present mem_a; the resulting memory read data is ignored.
- FIFO: 2 entries, count 0..2, head drives resp_data/resp_err, resp_valid = (count != 0).
- Pop on resp_valid & resp_ready. Push and pop in the same cycle leave count unchanged and preserve order.
- req_ready = rst_n & ((count + rd_pend − pop) <= 1). This is combinational in resp_ready and independent of req_we. The FIFO therefore never overflows.
- Stores are also blocked while req_ready is low. This keeps strict program order.
- wr_err = acc & req_we & !in_range, combinational.
- busy = rd_pend | (count != 0).

## Timing
- Reset values:
  - rd_pend=0, count=0, FIFO pointers 0.
  - resp_valid=0, resp_data=0, resp_err=0.
  - req_ready=0 and mem_w=0 while rst_n is low.
  - wr_err=0, busy=0.
- Load latency: accepted in cycle N → resp_valid high in cycle N+2.
- Throughput: one load per cycle sustained while resp_ready=1.
- With resp_ready=0, at most 2 loads are accepted, then req_ready=0. The head is held stable until popped.
- Store followed by a load of the same address in the next cycle returns the new data.
- Reset asserted mid-operation: pending load and FIFO contents are discarded immediately. There is no response after release.
- Empty FIFO with resp_ready=1: no pop, and count does not underflow.

## Configuration
- MEM_PORT_INITIATOR_RANGE_CHECK_EN
  - Defined: in_range = (req_addr <= MEM_LEN). Out-of-range stores are suppressed (mem_w=0, wr_err pulses). Out-of-range loads still occupy a pipeline slot and return data 0 with resp_err=1.
  - Undefined: in_range is constant 1, and resp_err and wr_err are tied 0.

## Test plan
- Store 0xDEADBEEF to 0x0010, then load 0x0010 next cycle, resp_ready=1 → resp_data=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after load acceptance.
- Preload 0x0000..0x0003 with 0x11..0x44, 4 back-to-back loads, resp_ready=1 → req_ready stays 1, responses 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles.
- Same 4 loads with resp_ready=0 → exactly 2 accepted, req_ready=0, head holds 0x11. Raise resp_ready → remaining responses 0x22, 0x33, 0x44 in order, none lost or duplicated.
- Accept a load, assert rst_n=0 the next cycle for 2 cycles → resp_valid, busy, mem_w, req_ready all 0. After release, no stale response appears.
- With the macro defined and MEM_LEN=0x00FF:
  - Store to 0x0100 → mem_w=0, wr_err pulses one cycle.
  - Load 0x0100 → resp_data=0, resp_err=1.
  - Load 0x00FF → normal data, resp_err=0.
- Without the macro, repeat the previous case → the store is written and resp_err and wr_err stay 0.
